// File: rtl/ex_div.sv
// ex_div: 32-bit restoring divider for the EX stage (DIV / DIVU).
// One quotient bit per clock, 32 iterations. Signed operands are divided as
// magnitudes and the signs of the quotient and remainder are applied when the
// result is produced.
// Optional feature: define DIV_ZERO_CHECK_EN to short-circuit a zero divisor
// through the BYZERO state (result 0, ready one edge after sampling).
// Without it a zero divisor runs the normal 32 iterations.
module ex_div (
    input  logic        clk,
    input  logic        resetn,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    localparam logic [1:0] ST_FREE   = 2'd0;
`ifdef DIV_ZERO_CHECK_EN
    localparam logic [1:0] ST_BYZERO = 2'd1;
`endif
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_END    = 2'd3;

    logic [1:0]  state_r;
    logic [5:0]  cnt_r;
    logic [31:0] rem_r;      // partial remainder
    logic [31:0] quo_r;      // dividend bits shift out, quotient bits shift in
    logic [31:0] dvs_r;      // divisor magnitude
    logic        sign_q_r;
    logic        sign_r_r;
    logic [63:0] result_r;
    logic        ready_r;
    logic        busy_r;

    logic [32:0] upper_s;
    logic        fits_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [31:0] fix_q_s;
    logic [31:0] fix_r_s;

    // Two's-complement negation modulo 2^32.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return 32'd0 - v;
    endfunction

    // Magnitude of a value; only applied when the operation is signed.
    function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] v);
        logic [31:0] m;
        if (sgn && v[31]) begin
            m = neg32(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        upper_s    = {rem_r, quo_r[31]};
        fits_s     = (upper_s >= {1'b0, dvs_r});
        rem_next_s = upper_s[31:0];
        quo_next_s = {quo_r[30:0], 1'b0};
        if (fits_s) begin
            rem_next_s = upper_s[31:0] - dvs_r;
            quo_next_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_next_s = upper_s[31:0];
            quo_next_s = {quo_r[30:0], 1'b0};
        end
    end

    // Sign fixup applied to the final iteration's outcome.
    always_comb begin
        fix_q_s = quo_next_s;
        fix_r_s = rem_next_s;
        if (sign_q_r) begin
            fix_q_s = neg32(quo_next_s);
        end else begin
            fix_q_s = quo_next_s;
        end
        if (sign_r_r) begin
            fix_r_s = neg32(rem_next_s);
        end else begin
            fix_r_s = rem_next_s;
        end
    end

    // Divider FSM and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_FREE;
            cnt_r    <= 6'd0;
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            dvs_r    <= 32'd0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            result_r <= 64'd0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_FREE: begin
                    result_r <= 64'd0;
                    ready_r  <= 1'b0;
                    if (start_i && !annul_i) begin
                        sign_q_r <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        sign_r_r <= signed_div_i & opdata1_i[31];
                        quo_r    <= mag32(signed_div_i, opdata1_i);
                        dvs_r    <= mag32(signed_div_i, opdata2_i);
                        rem_r    <= 32'd0;
                        cnt_r    <= 6'd0;
                        busy_r   <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                        if (opdata2_i == 32'd0) begin
                            state_r <= ST_BYZERO;
                        end else begin
                            state_r <= ST_ON;
                        end
`else
                        state_r <= ST_ON;
`endif
                    end else begin
                        state_r <= ST_FREE;
                        busy_r  <= 1'b0;
                    end
                end
`ifdef DIV_ZERO_CHECK_EN
                ST_BYZERO: begin
                    busy_r   <= 1'b0;
                    result_r <= 64'd0;
                    if (annul_i) begin
                        state_r <= ST_FREE;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_END;
                        ready_r <= 1'b1;
                    end
                end
`endif
                ST_ON: begin
                    if (annul_i) begin
                        state_r  <= ST_FREE;
                        cnt_r    <= 6'd0;
                        rem_r    <= 32'd0;
                        quo_r    <= 32'd0;
                        busy_r   <= 1'b0;
                        ready_r  <= 1'b0;
                        result_r <= 64'd0;
                    end else begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                        if (cnt_r == 6'd31) begin
                            state_r  <= ST_END;
                            cnt_r    <= 6'd0;
                            busy_r   <= 1'b0;
                            ready_r  <= 1'b1;
                            result_r <= {fix_r_s, fix_q_s};
                        end else begin
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                end
                ST_END: begin
                    busy_r <= 1'b0;
                    if (annul_i || !start_i) begin
                        state_r  <= ST_FREE;
                        ready_r  <= 1'b0;
                        result_r <= 64'd0;
                    end else begin
                        state_r <= ST_END;
                    end
                end
                default: begin
                    state_r  <= ST_FREE;
                    cnt_r    <= 6'd0;
                    busy_r   <= 1'b0;
                    ready_r  <= 1'b0;
                    result_r <= 64'd0;
                end
            endcase
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;
    assign busy_o   = busy_r;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: scoreboard bench for ex_div. Stimulus pushes the expected result
// and latency; a monitor pops on each rising ready_o and compares.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    ex_div dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [63:0] held_exp = 64'd0;
    logic        ready_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: {remainder, quotient} from plain arithmetic.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_CHECK_EN
            return 64'd0;
`else
            // Quotient all-ones, remainder |a|, then signs of a applied.
            if (sgn && a[31]) return {a, 32'h0000_0001};
            else              return {a, 32'hFFFF_FFFF};
`endif
        end
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        q32 = q[31:0];
        r32 = r[31:0];
        return {r32, q32};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_CHECK_EN
        if (b == 32'd0) return 1;
`endif
        return 32;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: pop and compare on each new result, check hold/idle values.
    always @(negedge clk) begin
        if (ready_o && !ready_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=%h expected=no_result", result_o);
            end else begin
                cur = sb_q.pop_front();
                chk("result", result_o, cur.res);
                chk("latency", 64'(cycle - cur.issue), 64'(cur.lat));
                held_exp = cur.res;
            end
        end else if (ready_o) begin
            chk("hold_stable", result_o, held_exp);
        end else begin
            chk("idle_zero", result_o, 64'd0);
        end
        ready_prev <= ready_o;
    end

    // Called at a negedge: drive a request; the next posedge samples it.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        exp_t e;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        if (push) begin
            e.res   = exp;
            e.issue = cycle + 1;
            e.lat   = exp_lat(b);
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
    endtask

    task automatic wait_done(input int hold);
        int n = 0;
        while (!ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1");
        end
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("release_ready", 64'(ready_o), 64'd0);
        chk("release_busy", 64'(busy_o), 64'd0);
    endtask

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int hold);
        issue(sgn, a, b, 1'b1, exp);
        wait_done(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        resetn       = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        #12;
        chk("reset_state", {result_o, ready_o, busy_o}, 66'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 3);
        run(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1);
`ifdef DIV_ZERO_CHECK_EN
        run(1'b0, 32'd5, 32'd0, 64'd0, 2);
`else
        run(1'b0, 32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF}, 2);
`endif

        // Annul on the 10th ON edge, then an immediate DIVU 9/3.
        issue(1'b0, $urandom, 32'd77, 1'b0, 64'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd9;
        opdata2_i    = 32'd3;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_busy", 64'(busy_o), 64'd0);
        chk("annul_ready", 64'(ready_o), 64'd0);
        run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

        // start and annul together in FREE stays idle.
        start_i = 1'b1;
        annul_i = 1'b1;
        @(negedge clk);
        chk("free_annul_busy", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-operation.
        issue(1'b0, 32'h1234_5678, 32'd3, 1'b0, 64'd0);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_outputs", {result_o, ready_o, busy_o}, 66'd0);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy_o), 64'd0);
        run(1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 1);

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom % 2);
            a   = $urandom;
            if (($urandom % 6) == 0) a = 32'h8000_0000;
            case ($urandom % 8)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom % 16);
                default: b = $urandom;
            endcase
            run(sgn, a, b, model(sgn, a, b), int'($urandom % 3));
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-004 SHALL have port opdata1_i  input  32  dividend, from the EX operand path.
REQ-005 SHALL have port opdata2_i  input  32  divisor.
REQ-006 SHALL have port start_i  input  1  request; held high by EX until ready_o is seen.
REQ-007 SHALL have port annul_i  input  1  cancel, driven by pipeline flush (exception or failed branch prediction).
REQ-008 SHALL have port result_o  output  64  {remainder -> HI [63:32], quotient -> LO [31:0]}.
REQ-009 SHALL have port ready_o  output  1  result_o valid.
REQ-010 SHALL have port busy_o  output  1  high in ON or BYZERO; EX ORs it into its stall request.

Function
REQ-011 SHALL implement a 4-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE: start_i=1 and annul_i=0 at an edge SHALL latch operands and signed_div_i, clear the 6-bit iteration counter, and go to ON (or BYZERO per REQ-026); otherwise stay FREE.
REQ-013 On latch, if signed, SHALL store |dividend| and |divisor| and record sign_q = sign(op1) XOR sign(op2) and sign_r = sign(op1).
REQ-014 ON SHALL perform one restoring iteration per edge: shift {partial remainder, dividend} left by 1, subtract divisor from the 33-bit upper part, and set the quotient bit to 1 with the difference kept if non-negative, else 0 with restore.
REQ-015 At the edge where the counter equals 31, SHALL complete the 32nd iteration and go to END; ready_o SHALL first be high 32 edges after the sampling edge.
REQ-016 Entering END SHALL apply sign fixup: quotient negated if sign_q, remainder negated if sign_r (signed only). All arithmetic is modulo 2^32.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0; no trap.
REQ-018 END: ready_o=1, result_o held stable; SHALL stay in END while start_i=1, and go to FREE (ready_o=0, result_o=0) at the first edge with start_i=0.
REQ-019 annul_i=1 at an edge in ON, BYZERO or END SHALL force FREE, ready_o=0, result_o=0, regardless of start_i; the partial result is discarded.
REQ-020 annul_i and start_i both high in FREE SHALL leave the FSM in FREE.
REQ-021 Operand input changes after the sampling edge SHALL NOT affect the result.
REQ-022 result_o SHALL be 0 in every state except END.

Reset
REQ-023 resetn=0 SHALL immediately (asynchronously) force FREE, counter 0, all internal registers 0, result_o=0, ready_o=0, busy_o=0.
REQ-024 Reset asserted mid-ON SHALL abort the operation; after release the first start_i SHALL begin a fresh, correct division.
REQ-025 Release SHALL be recognised at the first rising edge with resetn=1; no operation starts on the releasing edge unless start_i=1.

Configuration
REQ-026 Macro DIV_ZERO_CHECK_EN defined: a divisor of 0 at the sampling edge SHALL go to BYZERO, then to END on the next edge with result_o=0; ready_o is high one edge after sampling.
REQ-027 DIV_ZERO_CHECK_EN undefined: the BYZERO state is omitted, and a divisor of 0 SHALL run 32 ON iterations. Raw result: quotient 0xFFFFFFFF, remainder = |dividend|. The REQ-016 fixup then applies, with divisor 0 treated as positive.

Verification
REQ-028 DIVU 100/7, start held -> ready_o after exactly 32 edges, result_o = {0x00000002, 0x0000000E}; dropping start -> FREE, result_o=0.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-030 DIVU 5/0: with DIV_ZERO_CHECK_EN -> ready after 1 edge, result_o=0; without it -> ready after 32 edges, {0x00000005, 0xFFFFFFFF}.
REQ-031 annul_i pulsed on the 10th ON edge -> FREE next edge, ready_o never asserts; an immediate new DIVU 9/3 -> {0, 3} after 32 edges.
REQ-032 resetn low asynchronously mid-ON (between edges) -> busy_o/ready_o/result_o = 0 without a clock edge; after release, DIVU 0xFFFFFFFF/0x10 -> {0x0000000F, 0x0FFFFFFF}.
